// File: rtl/game_timer.sv
// Delay responder and level countdown for the game state controller.
// One-shot tick delays end in a single-cycle slowClk pulse; currentTime counts seconds down to 0.
module game_timer #(
    parameter int TICK_CYCLES = 500000,
    parameter int SEC_CYCLES  = 50000000,
    parameter int LEVEL_TIME  = 90
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        requestTime,
    input  logic [10:0] slowClkRequest,
    input  logic        pause,
    input  logic        timeReload,
    output logic        slowClk,
    output logic        delayBusy,
    output logic [23:0] currentTime,
    output logic        timeUp
);

    localparam int TICK_W = $clog2(TICK_CYCLES + 1);
    localparam int SEC_W  = $clog2(SEC_CYCLES + 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYCLES - 1);
    localparam logic [SEC_W-1:0]  SEC_LAST  = SEC_W'(SEC_CYCLES - 1);
    localparam logic [23:0]       LEVEL_LOAD = 24'(LEVEL_TIME);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DELAY = 2'd1;
    localparam logic [1:0] FIRE  = 2'd2;

    logic [1:0]        state, state_nxt;
    logic [10:0]       delay_cnt, delay_cnt_nxt;
    logic [TICK_W-1:0] tick_cnt, tick_cnt_nxt;
    logic [SEC_W-1:0]  sec_cnt, sec_cnt_nxt;
    logic [23:0]       time_nxt;

    function automatic logic [23:0] sat_dec(input logic [23:0] v);
        return (v == 24'd0) ? 24'd0 : v - 24'd1;
    endfunction

    // Delay engine next-state; a new request overrides whatever is pending.
    always_comb begin
        state_nxt     = state;
        delay_cnt_nxt = delay_cnt;
        tick_cnt_nxt  = tick_cnt;
        case (state)
            DELAY: begin
                if (tick_cnt == TICK_LAST) begin
                    tick_cnt_nxt  = '0;
                    delay_cnt_nxt = delay_cnt - 11'd1;
                    if (delay_cnt == 11'd1)
                        state_nxt = FIRE;
                end else begin
                    tick_cnt_nxt = tick_cnt + TICK_W'(1);
                end
            end
            // Holding FIRE while a pulse is still high keeps pulses one cycle apart.
            FIRE:    state_nxt = slowClk ? FIRE : IDLE;
            default: state_nxt = IDLE;
        endcase
        if (requestTime) begin
            delay_cnt_nxt = slowClkRequest;
            tick_cnt_nxt  = '0;
            state_nxt     = (slowClkRequest == 11'd0) ? FIRE : DELAY;
        end
    end

    always_comb begin
        sec_cnt_nxt = sec_cnt;
        time_nxt    = currentTime;
        if (timeReload) begin
            sec_cnt_nxt = '0;
            time_nxt    = LEVEL_LOAD;
        end else if (!pause && currentTime != 24'd0) begin
            if (sec_cnt == SEC_LAST) begin
                sec_cnt_nxt = '0;
                time_nxt    = sat_dec(currentTime);
            end else begin
                sec_cnt_nxt = sec_cnt + SEC_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            delay_cnt   <= '0;
            tick_cnt    <= '0;
            slowClk     <= 1'b0;
            delayBusy   <= 1'b0;
            sec_cnt     <= '0;
            currentTime <= LEVEL_LOAD;
            timeUp      <= 1'b0;
        end else begin
            state       <= state_nxt;
            delay_cnt   <= delay_cnt_nxt;
            tick_cnt    <= tick_cnt_nxt;
            slowClk     <= (state == FIRE) && !slowClk;
            delayBusy   <= (state_nxt == DELAY);
            sec_cnt     <= sec_cnt_nxt;
            currentTime <= time_nxt;
            timeUp      <= (time_nxt == 24'd0);
        end
    end

endmodule

// File: tb/tb_game_timer.sv
// Directed bench for game_timer with TICK_CYCLES=4, SEC_CYCLES=10, LEVEL_TIME=3.
module tb_game_timer;

    logic        clk = 1'b0;
    logic        reset;
    logic        requestTime;
    logic [10:0] slowClkRequest;
    logic        pause;
    logic        timeReload;
    logic        slowClk;
    logic        delayBusy;
    logic [23:0] currentTime;
    logic        timeUp;

    int n_checks = 0;
    int n_fail   = 0;
    logic seen;

    game_timer #(.TICK_CYCLES(4), .SEC_CYCLES(10), .LEVEL_TIME(3)) dut (
        .clk            (clk),
        .reset          (reset),
        .requestTime    (requestTime),
        .slowClkRequest (slowClkRequest),
        .pause          (pause),
        .timeReload     (timeReload),
        .slowClk        (slowClk),
        .delayBusy      (delayBusy),
        .currentTime    (currentTime),
        .timeUp         (timeUp)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b1; requestTime = 1'b0; slowClkRequest = '0;
        pause = 1'b0; timeReload = 1'b0;
        step(2);
        chk("rst_time", currentTime, 3);
        chk("rst_timeup", timeUp, 0);
        chk("rst_slowclk", slowClk, 0);
        chk("rst_busy", delayBusy, 0);

        // Free-running countdown from reset release
        reset = 1'b0;
        step(9);  chk("cd_e9", currentTime, 3);
        step(1);  chk("cd_e10", currentTime, 2);
        chk("cd_e10_up", timeUp, 0);
        step(10); chk("cd_e20", currentTime, 1);
        step(9);  chk("cd_e29", currentTime, 1);
        step(1);  chk("cd_e30", currentTime, 0);
        chk("cd_e30_up", timeUp, 1);
        step(15); chk("cd_hold", currentTime, 0);
        chk("cd_hold_up", timeUp, 1);

        // Delay of 5 ticks
        requestTime = 1'b1; slowClkRequest = 11'd5;
        step(1); requestTime = 1'b0;
        chk("d5_busy_k", delayBusy, 1);
        step(19);
        chk("d5_busy_k19", delayBusy, 1);
        chk("d5_clk_k19", slowClk, 0);
        step(1);
        chk("d5_busy_k20", delayBusy, 0);
        chk("d5_clk_k20", slowClk, 0);
        step(1);
        chk("d5_clk_k21", slowClk, 1);
        chk("d5_busy_k21", delayBusy, 0);
        step(1);
        chk("d5_clk_k22", slowClk, 0);

        // Zero-length delay
        requestTime = 1'b1; slowClkRequest = 11'd0;
        step(1); requestTime = 1'b0;
        chk("d0_clk_k", slowClk, 0);
        chk("d0_busy_k", delayBusy, 0);
        step(1);
        chk("d0_clk_k1", slowClk, 1);
        chk("d0_busy_k1", delayBusy, 0);
        step(1);
        chk("d0_clk_k2", slowClk, 0);

        // Re-request mid-delay: 5 then 2 eight cycles later
        requestTime = 1'b1; slowClkRequest = 11'd5;
        step(1); requestTime = 1'b0;
        step(7);
        requestTime = 1'b1; slowClkRequest = 11'd2;
        step(1); requestTime = 1'b0;
        chk("rr_busy_k8", delayBusy, 1);
        step(7);
        chk("rr_clk_k15", slowClk, 0);
        chk("rr_busy_k15", delayBusy, 1);
        step(1);
        chk("rr_busy_k16", delayBusy, 0);
        step(1);
        chk("rr_clk_k17", slowClk, 1);
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(1);
            if (slowClk) seen = 1'b1;
        end
        chk("rr_no_second_pulse", seen, 0);

        // Pause mid-interval, then resume
        timeReload = 1'b1;
        step(1); timeReload = 1'b0;
        chk("rl_time", currentTime, 3);
        chk("rl_timeup", timeUp, 0);
        step(4);
        pause = 1'b1;
        step(25);
        chk("pause_time", currentTime, 3);
        pause = 1'b0;
        step(5);  chk("resume_r34", currentTime, 3);
        step(1);  chk("resume_r35", currentTime, 2);
        step(10); chk("resume_r45", currentTime, 1);
        step(10); chk("resume_r55", currentTime, 0);
        chk("resume_up", timeUp, 1);

        // Reload at zero, then reload beating a decrement
        timeReload = 1'b1;
        step(1); timeReload = 1'b0;
        chk("rl0_time", currentTime, 3);
        chk("rl0_timeup", timeUp, 0);
        step(9);
        timeReload = 1'b1;
        step(1); timeReload = 1'b0;
        chk("rl_prio_time", currentTime, 3);
        step(9);  chk("rl_prio_e9", currentTime, 3);
        step(1);  chk("rl_prio_e10", currentTime, 2);

        // Reset in the middle of a delay
        requestTime = 1'b1; slowClkRequest = 11'd5;
        step(1); requestTime = 1'b0;
        step(3);
        chk("mid_busy", delayBusy, 1);
        #1 reset = 1'b1;
        #1;
        chk("arst_busy", delayBusy, 0);
        chk("arst_clk", slowClk, 0);
        chk("arst_time", currentTime, 3);
        chk("arst_up", timeUp, 0);
        step(2);
        reset = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step(1);
            if (slowClk || delayBusy) seen = 1'b1;
        end
        chk("arst_no_pulse", seen, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/game_timer.md
Name: game_timer

Overview:
- Timing responder for the game state controller.
- Services one-shot delay requests (`requestTime` with `slowClkRequest`) and returns a single-cycle `slowClk` completion pulse.
- Maintains the per-level countdown `currentTime`, which the controller treats as player death when it reaches 0.
- Sits beside the game FSM at top level, clocked by the system clock.

Parameters:
- TICK_CYCLES, 500000, clk cycles per delay tick (10 ms at 50 MHz); must be ≥1.
- SEC_CYCLES, 50000000, clk cycles per countdown step (1 s); must be ≥1.
- LEVEL_TIME, 90, countdown load value; must fit in 24 bits and be ≥1.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous reset, active-high.
- requestTime  in  1  single-cycle delay request strobe.
- slowClkRequest  in  11  delay length in ticks; sampled only when requestTime=1.
- pause  in  1  freezes the countdown (delay engine is not affected).
- timeReload  in  1  single-cycle strobe: reload the countdown to LEVEL_TIME.
- slowClk  out  1  single-cycle pulse when the requested delay expires.
- delayBusy  out  1  high while a delay is pending.
- currentTime  out  24  remaining level time in seconds.
- timeUp  out  1  high when currentTime==0.

Behaviour:
- Interface: one clock `clk`; reset is asynchronous and active-high (port `reset`).
- Reset values, asserted immediately and held while reset=1:
  - slowClk=0, delayBusy=0, state=IDLE.
  - Tick and second prescalers = 0, delay counter = 0.
  - currentTime=LEVEL_TIME, timeUp=0.
- Delay FSM states: IDLE, DELAY, FIRE. All outputs are registered.
- IDLE:
  - requestTime=1 latches slowClkRequest into the 11-bit delay counter N and clears the tick prescaler.
  - N=0 → go to FIRE.
  - N≥1 → go to DELAY.
- DELAY:
  - delayBusy=1.
  - Tick prescaler counts 0..TICK_CYCLES-1 and wraps; each wrap decrements N.
  - When N decrements 1→0, go to FIRE.
- FIRE:
  - slowClk=1 for exactly one cycle, delayBusy=0, then return to IDLE.
  - requestTime in this cycle is handled exactly as in IDLE.
- Latency, with the request sampled at edge k:
  - N=0: slowClk is high in the cycle after edge k+1.
  - N≥1: slowClk is high in the cycle after edge k+N*TICK_CYCLES+1.
- Re-request during DELAY: the latest request wins. N is reloaded, the prescaler is cleared, and only one slowClk is produced (for the new request).
- slowClk is never high in two consecutive cycles.
- Countdown:
  - The second prescaler counts 0..SEC_CYCLES-1 only while pause=0 and currentTime≠0; it holds its value while pause=1.
  - On wrap, currentTime decrements by 1 and saturates at 0, never wrapping to 0xFFFFFF.
- timeReload=1:
  - currentTime=LEVEL_TIME and the second prescaler is cleared at the next edge.
  - Takes priority over a decrement in the same cycle.
  - Does not disturb the delay FSM.
- timeUp is a registered copy of (next currentTime==0), so it is coincident with currentTime==0.
- Reset mid-delay: the pending request is discarded and no slowClk is emitted.

Test Plan (TICK_CYCLES=4, SEC_CYCLES=10, LEVEL_TIME=3):
- Reset release, no stimulus, pause=0 → currentTime 3→2→1→0 at 10-cycle intervals, then timeUp=1 and the value holds at 0 (no wrap).
- requestTime with slowClkRequest=5 → delayBusy=1 for 20 cycles, then slowClk high for exactly 1 cycle, 21 cycles after the request edge; delayBusy=0 afterwards.
- requestTime with slowClkRequest=0 → slowClk high for 1 cycle, 1 cycle after the request edge; delayBusy never asserts.
- requestTime=5; after 8 cycles requestTime=2 → a single slowClk, 9 cycles after the second request; no pulse at the original expiry.
- pause=1 for 25 cycles mid-count → currentTime and the second prescaler frozen; resuming completes the remaining part of the interrupted interval; timeReload at currentTime=0 → currentTime=3 and timeUp=0 next cycle.
- reset asserted during DELAY → outputs at reset values immediately; slowClk never pulses after release.
